// File: rtl/full_adder_bh_if.sv
// Operand, enable and result bundle for full_adder_bh.
// The master drives the operands and enable; the slave (the adder) drives the results.
interface full_adder_bh_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             en;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic [CNT_W-1:0] carry_cnt;
    logic             cnt_sat;

    modport master (
        output a, b, cin, en,
        input  s, cout, s_q, cout_q, carry_cnt, cnt_sat
    );

    modport slave (
        input  a, b, cin, en,
        output s, cout, s_q, cout_q, carry_cnt, cnt_sat
    );
endinterface

// File: rtl/full_adder_bh.sv
// WIDTH-bit full adder with a combinational result, an enable-gated registered copy
// of that result, and a saturating count of captured carry-outs.
module full_adder_bh #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    full_adder_bh_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_reg_d, sum_reg_q;
    logic             carry_reg_d, carry_reg_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Computed at WIDTH+1 bits so the top bit is the carry-out; X on any input propagates.
    always_comb begin
        sum_full = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    end

    always_comb begin
        sum_reg_d   = sum_reg_q;
        carry_reg_d = carry_reg_q;
        cnt_d       = cnt_q;
        if (bus.en) begin
            sum_reg_d   = sum_full[WIDTH-1:0];
            carry_reg_d = sum_full[WIDTH];
            if (sum_full[WIDTH] && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg_q   <= '0;
            carry_reg_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sum_reg_q   <= sum_reg_d;
            carry_reg_q <= carry_reg_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.s         = sum_full[WIDTH-1:0];
    assign bus.cout      = sum_full[WIDTH];
    assign bus.s_q       = sum_reg_q;
    assign bus.cout_q    = carry_reg_q;
    assign bus.carry_cnt = cnt_q;
    assign bus.cnt_sat   = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_full_adder_bh.sv
// Directed, table-driven bench for full_adder_bh: a 1-bit/8-bit-counter instance and a
// 4-bit/2-bit-counter instance for wrap and saturation cases.
module tb_full_adder_bh;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    full_adder_bh_if #(.WIDTH(1), .CNT_W(8)) i1 ();
    full_adder_bh_if #(.WIDTH(4), .CNT_W(2)) i2 ();

    full_adder_bh #(.WIDTH(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    full_adder_bh #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       cout;
    } vec_t;

    vec_t v1 [8];
    vec_t v4 [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_regs1(input string tag, input logic [31:0] sq, input logic [31:0] cq,
                             input logic [31:0] cnt);
        chk({tag, ".s_q"},       32'(i1.s_q),       sq);
        chk({tag, ".cout_q"},    32'(i1.cout_q),    cq);
        chk({tag, ".carry_cnt"}, 32'(i1.carry_cnt), cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // {a, b, cin} -> {s, cout}, hand-computed
        v1[0] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0};
        v1[1] = '{4'd0, 4'd0, 1'b1, 4'd1, 1'b0};
        v1[2] = '{4'd0, 4'd1, 1'b0, 4'd1, 1'b0};
        v1[3] = '{4'd0, 4'd1, 1'b1, 4'd0, 1'b1};
        v1[4] = '{4'd1, 4'd0, 1'b0, 4'd1, 1'b0};
        v1[5] = '{4'd1, 4'd0, 1'b1, 4'd0, 1'b1};
        v1[6] = '{4'd1, 4'd1, 1'b0, 4'd0, 1'b1};
        v1[7] = '{4'd1, 4'd1, 1'b1, 4'd1, 1'b1};

        v4[0] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        v4[1] = '{4'd9,  4'd8,  1'b1, 4'd2,  1'b1};
        v4[2] = '{4'd7,  4'd8,  1'b0, 4'd15, 1'b0};
        v4[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        v4[4] = '{4'd3,  4'd4,  1'b0, 4'd7,  1'b0};

        rst_n = 1'b0;
        i1.a = 1'b0; i1.b = 1'b0; i1.cin = 1'b0; i1.en = 1'b0;
        i2.a = 4'd0; i2.b = 4'd0; i2.cin = 1'b0; i2.en = 1'b0;
        #1;

        // Reset state, combinational path live while reset is held
        chk_regs1("rst", 0, 0, 0);
        chk("rst.cnt_sat", 32'(i1.cnt_sat), 0);
        chk("rst.dut2.carry_cnt", 32'(i2.carry_cnt), 0);
        chk("rst.dut2.cnt_sat", 32'(i2.cnt_sat), 0);
        chk("rst.s_000", 32'(i1.s), 0);
        chk("rst.cout_000", 32'(i1.cout), 0);
        i1.a = 1'b1; #1;
        chk("rst.s_a1", 32'(i1.s), 1);
        chk("rst.cout_a1", 32'(i1.cout), 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 1-bit sweep
        for (int i = 0; i < 8; i++) begin
            i1.a = v1[i].a[0]; i1.b = v1[i].b[0]; i1.cin = v1[i].cin;
            #1;
            chk($sformatf("w1.s[%0d]", i),    32'(i1.s),    32'(v1[i].s[0]));
            chk($sformatf("w1.cout[%0d]", i), 32'(i1.cout), 32'(v1[i].cout));
        end

        // 4-bit wrap: overflow visible only through cout
        for (int i = 0; i < 5; i++) begin
            i2.a = v4[i].a; i2.b = v4[i].b; i2.cin = v4[i].cin;
            #1;
            chk($sformatf("w4.s[%0d]", i),    32'(i2.s),    32'(v4[i].s));
            chk($sformatf("w4.cout[%0d]", i), 32'(i2.cout), 32'(v4[i].cout));
        end

        // en=0 across a clock: registers stay at reset values
        tick();
        chk_regs1("en0_idle", 0, 0, 0);

        // Capture 1+1+1
        @(negedge clk);
        i1.a = 1'b1; i1.b = 1'b1; i1.cin = 1'b1; i1.en = 1'b1;
        tick();
        chk_regs1("cap111", 1, 1, 1);

        // Hold with en=0 while inputs change
        @(negedge clk);
        i1.en = 1'b0; i1.a = 1'b0; i1.b = 1'b0; i1.cin = 1'b0;
        tick();
        chk_regs1("hold", 1, 1, 1);
        chk("hold.s_live", 32'(i1.s), 0);

        // Saturation on 2-bit counter: 5 carry captures -> 3, no wrap
        @(negedge clk);
        i2.a = 4'd15; i2.b = 4'd1; i2.cin = 1'b0; i2.en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("sat.cnt[%0d]", k), 32'(i2.carry_cnt), (k >= 3) ? 3 : k);
            chk($sformatf("sat.flag[%0d]", k), 32'(i2.cnt_sat), (k >= 3) ? 1 : 0);
        end
        chk("sat.s_q", 32'(i2.s_q), 0);
        chk("sat.cout_q", 32'(i2.cout_q), 1);

        // No carry captured: sum registered, count unchanged
        @(negedge clk);
        i2.a = 4'd1; i2.b = 4'd1; i2.cin = 1'b0;
        tick();
        chk("nocarry.s_q", 32'(i2.s_q), 2);
        chk("nocarry.cout_q", 32'(i2.cout_q), 0);
        chk("nocarry.cnt", 32'(i2.carry_cnt), 3);

        // Count more carries on dut1, then async reset between edges
        @(negedge clk);
        i1.a = 1'b1; i1.b = 1'b1; i1.cin = 1'b0; i1.en = 1'b1;
        i2.a = 4'd8; i2.b = 4'd8; i2.cin = 1'b1;
        tick();
        chk_regs1("precnt", 0, 1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs1("midrst", 0, 0, 0);
        chk("midrst.dut2.s_q", 32'(i2.s_q), 0);
        chk("midrst.dut2.cnt", 32'(i2.carry_cnt), 0);
        chk("midrst.dut2.sat", 32'(i2.cnt_sat), 0);
        chk("midrst.s_live", 32'(i2.s), 1);
        chk("midrst.cout_live", 32'(i2.cout), 1);
        i2.a = 4'd2; #1;
        chk("midrst.s_track", 32'(i2.s), 11);
        chk("midrst.cout_track", 32'(i2.cout), 0);

        // Reset held across an edge, then released: values hold until next edge
        tick();
        chk_regs1("rst_edge", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_regs1("post_rel", 0, 0, 0);
        tick();
        chk_regs1("first_cap", 0, 1, 1);
        chk("first_cap.dut2.s_q", 32'(i2.s_q), 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
